partial_scan_test_ctrl: RTL and testbench

//  Sequences partial-scan testing of the fourFunc arithmetic datapath. Generates

---
 rtl/partial_scan_test_ctrl_if.sv | 32 +++
 rtl/partial_scan_test_ctrl.sv | 137 +++++++++++++
 tb/tb_partial_scan_test_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/partial_scan_test_ctrl_if.sv
// Tester/scan-chain bundle for the fourFunc partial-scan controller.
// The slave side is the controller, the master side is the tester plus chain.
interface partial_scan_test_ctrl_if #(
  parameter int PAT_W = 8
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] num_patterns;
  logic [15:0]      golden_sig;
  logic             scan_out;
  logic             NbarT;
  logic             scan_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [15:0]      sig;
  logic [PAT_W-1:0] pat_idx;

  modport master (
    output start, abort, num_patterns,
    output golden_sig, scan_out,
    input  NbarT, scan_in, busy, done,
    input  pass, sig, pat_idx
  );

  modport slave (
    input  start, abort, num_patterns,
    input  golden_sig, scan_out,
    output NbarT, scan_in, busy, done,
    output pass, sig, pat_idx
  );
endinterface

// File: rtl/partial_scan_test_ctrl.sv
// LFSR-driven partial-scan sequencer for fourFunc with MISR compaction.
// Loads of pattern p overlap the unload of response p-1.
module partial_scan_test_ctrl #(
  parameter int          CHAIN_LEN = 16,
  parameter int          PAT_W     = 8,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input logic                    clk,
  input logic                    rst,
  partial_scan_test_ctrl_if.slave bus
);

  localparam int CW = (CHAIN_LEN > 2) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CAPTURE,
    FLUSH,
    DONE
  } state_t;

  state_t           state;
  logic [15:0]      lfsr;
  logic [CW-1:0]    shift_cnt;
  logic [PAT_W-1:0] npat;

  logic [15:0]      lfsr_nxt;
  logic [15:0]      misr_nxt;
  logic [PAT_W-1:0] pat_inc;
  logic             shift_end;

  assign lfsr_nxt  = {lfsr[14:0],
                      lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign misr_nxt  = {bus.sig[14:0],
                      bus.sig[15] ^ bus.sig[13] ^ bus.sig[12]
                      ^ bus.sig[10] ^ bus.scan_out};
  assign pat_inc   = bus.pat_idx + PAT_W'(1);
  assign shift_end = (shift_cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      lfsr        <= SEED;
      shift_cnt   <= '0;
      npat        <= '0;
      bus.NbarT   <= 1'b0;
      bus.scan_in <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.pass    <= 1'b0;
      bus.sig     <= '0;
      bus.pat_idx <= '0;
    end else begin
      bus.done <= 1'b0;
      // abort freezes sig/pat_idx so the tester can inspect progress
      if (bus.abort && state != IDLE) begin
        state       <= IDLE;
        bus.NbarT   <= 1'b0;
        bus.scan_in <= 1'b0;
        bus.busy    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start) begin
              lfsr        <= SEED;
              shift_cnt   <= '0;
              npat        <= bus.num_patterns;
              bus.sig     <= '0;
              bus.pat_idx <= '0;
              if (bus.num_patterns != '0) begin
                state       <= SHIFT;
                bus.NbarT   <= 1'b1;
                bus.busy    <= 1'b1;
                bus.scan_in <= SEED[15];
                bus.pass    <= 1'b0;
              end else begin
                state    <= DONE;
                bus.done <= 1'b1;
                bus.pass <= (bus.golden_sig == 16'h0000);
              end
            end
          end
          SHIFT: begin
            lfsr <= lfsr_nxt;
            if (bus.pat_idx != '0) begin
              bus.sig <= misr_nxt;
            end
            if (shift_end) begin
              state       <= CAPTURE;
              shift_cnt   <= '0;
              bus.NbarT   <= 1'b0;
              bus.scan_in <= 1'b0;
            end else begin
              shift_cnt   <= shift_cnt + CW'(1);
              bus.scan_in <= lfsr_nxt[15];
            end
          end
          CAPTURE: begin
            bus.NbarT <= 1'b1;
            if (bus.pat_idx != npat) begin
              bus.pat_idx <= pat_inc;
            end
            if (pat_inc == npat) begin
              state       <= FLUSH;
              bus.scan_in <= 1'b0;
            end else begin
              state       <= SHIFT;
              bus.scan_in <= lfsr[15];
            end
          end
          FLUSH: begin
            bus.sig <= misr_nxt;
            if (shift_end) begin
              state     <= DONE;
              shift_cnt <= '0;
              bus.NbarT <= 1'b0;
              bus.busy  <= 1'b0;
              bus.done  <= 1'b1;
              bus.pass  <= (misr_nxt == bus.golden_sig);
            end else begin
              shift_cnt <= shift_cnt + CW'(1);
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_partial_scan_test_ctrl.sv
// Bench for partial_scan_test_ctrl: loopback chain model and a
// stream-level signature model (MISR over the first N*L LFSR bits).
module tb_partial_scan_test_ctrl;

  localparam int L     = 16;
  localparam int PAT_W = 8;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int SMAX  = 4096;

  logic clk = 1'b0;
  logic rst;

  partial_scan_test_ctrl_if #(.PAT_W(PAT_W)) bus ();

  partial_scan_test_ctrl #(
    .CHAIN_LEN (L),
    .PAT_W     (PAT_W),
    .SEED      (SEED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   errs    = 0;
  bit   stream [0:SMAX-1];
  logic [L-1:0] chain;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signature of the first k bits of the pattern stream.
  function automatic logic [15:0] misr_of(input int k);
    logic [15:0] s;
    s = 16'h0000;
    for (int j = 0; j < k; j++) begin
      s = {s[14:0], (^(s & 16'hB400)) ^ stream[j]};
    end
    return s;
  endfunction

  // One clock; the chain shifts what was on scan_in while NbarT was high.
  task automatic tick();
    logic nb;
    logic si;
    nb = bus.NbarT;
    si = bus.scan_in;
    @(posedge clk);
    #1;
    if (nb === 1'b1) begin
      chain = {chain[L-2:0], si};
    end
    bus.scan_out = chain[L-1];
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_nbart"}, 32'(bus.NbarT), 32'd0);
    chk({tag, "_scan_in"}, 32'(bus.scan_in), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_pass"}, 32'(bus.pass), 32'd0);
    chk({tag, "_sig"}, 32'(bus.sig), 32'd0);
    chk({tag, "_pat_idx"}, 32'(bus.pat_idx), 32'd0);
  endtask

  // Start at edge 0; cycle c is the period that follows edge c-1.
  task automatic session(input int n,
                         input logic [15:0] gold,
                         input int abort_at,
                         input bit repulse);
    int dc;
    int endc;
    int cons;
    int pexp;
    logic [15:0] esig;
    dc   = (n == 0) ? 1 : n * (L + 1) + L + 1;
    endc = (abort_at > 0) ? abort_at + 3 : dc + 1;
    esig = misr_of(n * L);
    bus.num_patterns = PAT_W'(n);
    bus.golden_sig   = gold;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= endc; c++) begin
      bit live;
      bit shf;
      bit esi;
      live = (abort_at == 0) || (c <= abort_at);
      shf  = live && (c < dc) && (c % (L + 1) != 0);
      esi  = 1'b0;
      if (shf && c < n * (L + 1)) begin
        esi = stream[(c / (L + 1)) * L + c % (L + 1) - 1];
      end
      bus.start = repulse && (c == 5 || c == 40);
      bus.abort = (c == abort_at);
      bus.num_patterns = PAT_W'($urandom);
      chk("busy", 32'(bus.busy), 32'(live && c < dc));
      chk("nbart", 32'(bus.NbarT), 32'(shf));
      chk("scan_in", 32'(bus.scan_in), 32'(esi));
      chk("done", 32'(bus.done), 32'(abort_at == 0 && c == dc));
      if (c == 1 && dc != 1) begin
        chk("pass_clr", 32'(bus.pass), 32'd0);
      end
      if (abort_at == 0 && c >= dc) begin
        chk("pass", 32'(bus.pass), 32'(esig == gold));
        chk("sig", 32'(bus.sig), 32'(esig));
        chk("pat_idx", 32'(bus.pat_idx), 32'(n));
      end
      if (abort_at > 0 && c == abort_at + 1) begin
        cons = 0;
        pexp = 0;
        for (int k = 1; k < abort_at; k++) begin
          if ((k > L + 1 && k % (L + 1) != 0 && k < n * (L + 1)) ||
              (k > n * (L + 1) && k <= n * (L + 1) + L)) begin
            cons++;
          end
        end
        for (int k = 1; k <= n; k++) begin
          if (k * (L + 1) < abort_at) pexp++;
        end
        chk("abort_sig", 32'(bus.sig), 32'(misr_of(cons)));
        chk("abort_pat_idx", 32'(bus.pat_idx), 32'(pexp));
      end
      tick();
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  initial begin
    logic [15:0] l;
    logic [15:0] g;
    int n;
    int dc;
    int ab;

    l = SEED;
    for (int j = 0; j < SMAX; j++) begin
      stream[j] = l[15];
      l = {l[14:0], ^(l & 16'hB400)};
    end

    chain            = '0;
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.num_patterns = '0;
    bus.golden_sig   = '0;
    bus.scan_out     = 1'b0;
    #1 rst = 1'b0;
    #1 chk_reset("por");
    @(negedge clk);
    rst = 1'b1;

    // async reset in the middle of a shift burst
    bus.num_patterns = PAT_W'(3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    chk("pre_rst_nbart", 32'(bus.NbarT), 32'd1);
    #2 rst = 1'b0;
    #1 chk_reset("mid_rst");
    #1 rst = 1'b1;

    g = misr_of(3 * L);
    session(3, g, 0, 1'b0);
    session(3, g ^ 16'h0001, 0, 1'b0);
    session(0, 16'h0000, 0, 1'b0);
    session(0, 16'h0005, 0, 1'b0);
    session(3, g, 25, 1'b0);
    session(1, misr_of(L), 0, 1'b0);
    session(3, g, 0, 1'b1);

    for (int r = 0; r < 8; r++) begin
      n  = int'($urandom_range(1, 6));
      dc = n * (L + 1) + L + 1;
      g  = ($urandom_range(0, 1) == 0) ? misr_of(n * L) : 16'($urandom);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, dc - 1)) : 0;
      session(n, g, ab, 1'b0);
    end

    session(255, misr_of(255 * L), 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
